axis_square_pipe: RTL

AXIS_SQUARE_PIPE -- requirements
Module: axis_square_pipe

---
 rtl/axis_square_pipe.sv | 120 ++++++++++++
 1 files changed

// File: rtl/axis_square_pipe.sv
// AXI-Stream arithmetic stage: shift-left or square-of-lower-half, followed by a
// 2-entry in-order skid buffer with packet and beat counters on the output side.
module axis_square_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int MODE       = 0,
    parameter int SHIFT      = 1
) (
    input  logic                    axis_clk,
    input  logic                    axis_reset_n,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_Square_TDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXIS_Square_TKEEP,
    input  logic                    S_AXIS_Square_TLAST,
    input  logic                    S_AXIS_Square_TVALID,
    output logic                    S_AXIS_Square_TREADY,
    output logic [DATA_WIDTH-1:0]   M_AXIS_Square_TDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXIS_Square_TKEEP,
    output logic                    M_AXIS_Square_TLAST,
    output logic                    M_AXIS_Square_TVALID,
    input  logic                    M_AXIS_Square_TREADY,
    output logic [15:0]             pkt_count,
    output logic [15:0]             beat_count
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int HW = DATA_WIDTH / 2;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KW-1:0]         keep;
        logic                  last;
    } entry_t;

    entry_t                head, tail, head_nxt, tail_nxt, in_e;
    logic [1:0]            occ, occ_nxt;
    logic                  s_ready_q, m_valid_q;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] result;

    generate
        if (MODE == 1) begin : g_square
            // Zero-extend the lower half so the product is exact in DATA_WIDTH bits.
            logic [DATA_WIDTH-1:0] lo_ext;
            assign lo_ext = {{HW{1'b0}}, S_AXIS_Square_TDATA[HW-1:0]};
            assign result = lo_ext * lo_ext;
        end else begin : g_shift
            assign result = S_AXIS_Square_TDATA << SHIFT;
        end
    endgenerate

    assign in_e = '{data: result, keep: S_AXIS_Square_TKEEP, last: S_AXIS_Square_TLAST};

    assign push = S_AXIS_Square_TVALID & s_ready_q;
    assign pop  = m_valid_q & M_AXIS_Square_TREADY;

    always_comb begin
        head_nxt = head;
        tail_nxt = tail;
        occ_nxt  = occ;
        case (occ)
            2'd0: begin
                if (push) begin
                    head_nxt = in_e;
                    occ_nxt  = 2'd1;
                end
            end
            2'd1: begin
                case ({push, pop})
                    2'b10: begin
                        tail_nxt = in_e;
                        occ_nxt  = 2'd2;
                    end
                    2'b01: occ_nxt = 2'd0;
                    2'b11: head_nxt = in_e;
                    default: ;
                endcase
            end
            2'd2: begin
                // Ready is low when full, so only a pop can happen here.
                if (pop) begin
                    head_nxt = tail;
                    occ_nxt  = 2'd1;
                end
            end
            default: occ_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_reset_n) begin
            occ        <= 2'd0;
            head       <= '0;
            tail       <= '0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            pkt_count  <= 16'd0;
            beat_count <= 16'd0;
        end else begin
            occ       <= occ_nxt;
            head      <= head_nxt;
            tail      <= tail_nxt;
            s_ready_q <= (occ_nxt != 2'd2);
            m_valid_q <= (occ_nxt != 2'd0);
            if (pop) begin
                if (head.last) begin
                    pkt_count  <= pkt_count + 16'd1;
                    beat_count <= 16'd0;
                end else if (beat_count != 16'hFFFF) begin
                    beat_count <= beat_count + 16'd1;
                end
            end
        end
    end

    assign S_AXIS_Square_TREADY = s_ready_q;
    assign M_AXIS_Square_TVALID = m_valid_q;
    assign M_AXIS_Square_TDATA  = head.data;
    assign M_AXIS_Square_TKEEP  = head.keep;
    assign M_AXIS_Square_TLAST  = head.last;

endmodule
